// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA sync decoder: rebuilds raster position, checks timing, declares lock,
// emits active-area pixel coordinates and latches the colour at a probe coordinate.
`timescale 1ns/1ps
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 783,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 514,
  parameter bit SYNC_ACTIVE = 1'b1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_ce,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [11:0] rgb_in,
  input  logic [9:0]  probe_x,
  input  logic [8:0]  probe_y,
  output logic [9:0]  h_pos,
  output logic [9:0]  v_pos,
  output logic        pixel_valid,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err,
  output logic [7:0]  err_count,
  output logic [11:0] probe_rgb,
  output logic        probe_valid
);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_TRACK  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam int LW = $clog2(2 * H_TOTAL + 1);
  localparam int GW = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES + 1) : 1;

  localparam logic [9:0]    H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]    HA_START   = 10'(H_ACT_START);
  localparam logic [9:0]    HA_END     = 10'(H_ACT_END);
  localparam logic [9:0]    VA_START   = 10'(V_ACT_START);
  localparam logic [9:0]    VA_END     = 10'(V_ACT_END);
  localparam logic [8:0]    VA_START9  = 9'(V_ACT_START);
  localparam logic [LW-1:0] LOSS_LIMIT = LW'(2 * H_TOTAL);
  localparam logic [LW-1:0] LOSS_LAST  = LW'(2 * H_TOTAL - 1);
  localparam logic [GW-1:0] GOOD_LAST  = GW'(LOCK_FRAMES - 1);

  logic [1:0]    state;
  logic [GW-1:0] good_frames;
  logic          hs_r;
  logic          vs_h;
  logic          h_seen;
  logic          err_seen;
  logic [LW-1:0] lost_cnt;

  logic       hs_act, vs_act, h_edge, v_edge;
  logic       line_bad, frame_bad, err_now, sync_lost;
  logic       active, take_pix, probe_hit;
  logic [9:0] h_nxt, v_nxt;
  logic [8:0] y_rel;

  // Positions are decoded from the values being loaded this pix_ce, so pix_rgb,
  // pix_x/pix_y and h_pos/v_pos all describe the same sampled pixel.
  always_comb begin
    hs_act    = (hsync_in == SYNC_ACTIVE);
    vs_act    = (vsync_in == SYNC_ACTIVE);
    h_edge    = pix_ce & hs_act & ~hs_r;
    v_edge    = h_edge & vs_act & ~vs_h;
    line_bad  = h_edge & h_seen & (h_pos != H_LAST);
    frame_bad = v_edge & (v_pos != V_LAST);
    err_now   = (line_bad | frame_bad) & (state != S_SEARCH);
    sync_lost = pix_ce & ~h_edge & (lost_cnt == LOSS_LAST);

    h_nxt = h_pos;
    if (h_edge)
      h_nxt = '0;
    else if (pix_ce && h_pos != 10'h3FF)
      h_nxt = h_pos + 10'd1;

    v_nxt = v_pos;
    if (v_edge)
      v_nxt = '0;
    else if (h_edge && v_pos != 10'h3FF)
      v_nxt = v_pos + 10'd1;

    active    = (h_nxt >= HA_START) && (h_nxt <= HA_END) &&
                (v_nxt >= VA_START) && (v_nxt <= VA_END);
    take_pix  = pix_ce & locked & active;
    y_rel     = v_nxt[8:0] - VA_START9;
    probe_hit = pixel_valid & (pix_x == probe_x) & (pix_y == probe_y);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_r     <= 1'b0;
      vs_h     <= 1'b0;
      h_seen   <= 1'b0;
      lost_cnt <= '0;
      h_pos    <= '0;
      v_pos    <= '0;
    end else begin
      h_pos <= h_nxt;
      v_pos <= v_nxt;
      if (pix_ce)
        hs_r <= hs_act;
      if (h_edge)
        vs_h <= vs_act;
      if (h_edge)
        lost_cnt <= '0;
      else if (pix_ce && lost_cnt != LOSS_LIMIT)
        lost_cnt <= lost_cnt + LW'(1);
      if (sync_lost)
        h_seen <= 1'b0;
      else if (h_edge)
        h_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_SEARCH;
      good_frames <= '0;
      err_seen    <= 1'b0;
      locked      <= 1'b0;
      timing_err  <= 1'b0;
      frame_start <= 1'b0;
      err_count   <= '0;
    end else begin
      timing_err  <= err_now;
      frame_start <= v_edge;
      locked      <= (state == S_LOCKED);
      if (err_now && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
      // An error on the closing V-edge belongs to the frame that just ended.
      err_seen <= v_edge ? 1'b0 : (err_seen | err_now);

      if (sync_lost) begin
        state       <= S_SEARCH;
        good_frames <= '0;
      end else begin
        case (state)
          S_SEARCH: begin
            if (v_edge) begin
              state       <= S_TRACK;
              good_frames <= '0;
            end
          end
          S_TRACK: begin
            if (err_now)
              good_frames <= '0;
            else if (v_edge && !err_seen) begin
              if (good_frames == GOOD_LAST)
                state <= S_LOCKED;
              else
                good_frames <= good_frames + GW'(1);
            end
          end
          S_LOCKED: begin
            if (err_now) begin
              state       <= S_TRACK;
              good_frames <= '0;
            end
          end
          default: state <= S_SEARCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_valid <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      probe_valid <= 1'b0;
      probe_rgb   <= '0;
    end else begin
      pixel_valid <= take_pix;
      if (take_pix) begin
        pix_x   <= h_nxt - HA_START;
        pix_y   <= y_rel;
        pix_rgb <= rgb_in;
      end
      probe_valid <= probe_hit;
      if (probe_hit)
        probe_rgb <= pix_rgb;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - scoreboard bench for vga_sync_decoder on a reduced 32x16 raster
`timescale 1ns/1ps
module tb_vga_sync_decoder;

  localparam int HT = 32, VT = 16, HAS = 8, HAE = 27, VAS = 3, VAE = 12;
  localparam int HSW = 4, VSW = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_ce, hsync_in, vsync_in;
  logic [11:0] rgb_in;
  logic [9:0]  probe_x;
  logic [8:0]  probe_y;
  logic [9:0]  h_pos, v_pos, pix_x;
  logic [8:0]  pix_y;
  logic [11:0] pix_rgb, probe_rgb;
  logic        pixel_valid, frame_start, locked, timing_err, probe_valid;
  logic [7:0]  err_count;

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HAS), .H_ACT_END(HAE),
    .V_ACT_START(VAS), .V_ACT_END(VAE), .SYNC_ACTIVE(1'b1), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .rgb_in(rgb_in), .probe_x(probe_x), .probe_y(probe_y), .h_pos(h_pos), .v_pos(v_pos),
    .pixel_valid(pixel_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .locked(locked), .timing_err(timing_err),
    .err_count(err_count), .probe_rgb(probe_rgb), .probe_valid(probe_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [30:0] pix_q[$];
  logic [31:0] probe_q[$];
  int gx, gy;
  bit sb_on, probe_on, white;

  int te_cnt = 0, fs_cnt = 0, pv_cnt = 0, pr_cnt = 0;
  bit te_prev = 1'b0;
  logic lock_after_err = 1'b1;

  // Monitor: pops the scoreboards whenever the DUT reports a pixel or a probe hit.
  always @(negedge clk) begin
    if (te_prev)
      lock_after_err = locked;
    te_prev = timing_err;
    if (timing_err) te_cnt++;
    if (frame_start) fs_cnt++;
    if (pixel_valid) begin
      pv_cnt++;
      if (sb_on) begin
        if (pix_q.size() == 0) check("pix_extra", 1, 0);
        else check("pix", {pix_x, pix_y, pix_rgb}, pix_q.pop_front());
      end
    end
    if (probe_valid) begin
      pr_cnt++;
      if (probe_on) begin
        if (probe_q.size() == 0) check("probe_extra", 1, 0);
        else check("probe", {h_pos, v_pos, probe_rgb}, probe_q.pop_front());
      end
    end
  end

  task automatic step(input bit kill, input int len);
    logic [11:0] c;
    c = white ? 12'hFFF : 12'($urandom);
    @(negedge clk);
    pix_ce   = 1'b1;
    hsync_in = (gx < HSW) && !kill;
    vsync_in = (gy < VSW);
    rgb_in   = c;
    if (gx >= HAS && gx <= HAE && gy >= VAS && gy <= VAE) begin
      if (sb_on) pix_q.push_back({10'(gx - HAS), 9'(gy - VAS), c});
      if (probe_on && (gx - HAS) == int'(probe_x) && (gy - VAS) == int'(probe_y))
        probe_q.push_back({10'(gx), 10'(gy), c});
    end
    @(negedge clk);
    pix_ce = 1'b0;
    repeat (2) @(negedge clk);
    gx++;
    if (gx >= len) begin
      gx = 0;
      gy = (gy + 1) % VT;
    end
  endtask

  task automatic run_line(input int len);
    repeat (len) step(1'b0, len);
  endtask

  task automatic run_frames(input int n);
    repeat (n * VT) run_line(HT);
  endtask

  task automatic finish_frame();
    while (!(gx == 0 && gy == 0)) step(1'b0, HT);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int te0, fs0, pv0, pr0;
    rst_n = 1'b0; pix_ce = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; rgb_in = '0;
    probe_x = '0; probe_y = '0; gx = 0; gy = 0; sb_on = 0; probe_on = 0; white = 0;
    repeat (3) @(negedge clk);
    check("rst_pos", {h_pos, v_pos, pix_x, pix_y, pix_rgb}, 0);
    check("rst_flags", {pixel_valid, frame_start, locked, timing_err, err_count, probe_rgb, probe_valid}, 0);
    rst_n = 1'b1;

    // Initial acquisition: lock on the third V-edge.
    run_frames(2);
    check("lock_early", locked, 0);
    check("fs_two", fs_cnt, 2);
    run_frames(1);
    check("lock_third", locked, 1);
    check("fs_three", fs_cnt, 3);
    check("te_none", te_cnt, 0);
    check("errcnt_zero", err_count, 0);

    // One locked frame of random colours through the pixel scoreboard.
    pv0 = pv_cnt;
    sb_on = 1;
    run_frames(1);
    sb_on = 0;
    check("pv_per_frame", pv_cnt - pv0, (HAE - HAS + 1) * (VAE - VAS + 1));
    check("pix_q_empty", pix_q.size(), 0);

    // Probe at the first active pixel with white video, then the last with random video.
    white = 1; probe_x = 10'd0; probe_y = 9'd0; probe_on = 1; pr0 = pr_cnt;
    run_frames(1);
    check("probe00_cnt", pr_cnt - pr0, 1);
    check("probe00_rgb", probe_rgb, 12'hFFF);
    white = 0; probe_x = 10'(HAE - HAS); probe_y = 9'(VAE - VAS); pr0 = pr_cnt;
    run_frames(1);
    check("probe_last_cnt", pr_cnt - pr0, 1);
    check("probe_q_empty", probe_q.size(), 0);
    probe_on = 0;

    // A single 31-pixel line: one error, drop lock, relock after two clean frames.
    te0 = te_cnt;
    for (int y = 0; y < VT; y++) run_line((y == 5) ? HT - 1 : HT);
    check("short_te", te_cnt - te0, 1);
    check("short_errcnt", err_count, 1);
    check("short_lock_next_clk", lock_after_err, 0);
    run_frames(2);
    check("short_relock_early", locked, 0);
    run_frames(1);
    check("short_relock", locked, 1);
    check("short_te_total", te_cnt - te0, 1);

    // Hsync removed for 80 pix_ce (limit is 64): back to SEARCH, then 3 V-edges to relock.
    te0 = te_cnt; fs0 = fs_cnt; pv0 = pv_cnt;
    repeat (80) step(1'b1, HT);
    check("loss_unlocked", locked, 0);
    finish_frame();
    check("loss_no_pv", pv_cnt - pv0, 0);
    check("loss_no_fs", fs_cnt - fs0, 0);
    run_frames(2);
    check("loss_relock_early", locked, 0);
    run_frames(1);
    check("loss_relock", locked, 1);
    check("loss_te", te_cnt - te0, 0);

    // Asynchronous reset in the middle of a locked frame.
    while (gy != 6) step(1'b0, HT);
    repeat (10) step(1'b0, HT);
    check("rst_mid_pre_lock", locked, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_pos", {h_pos, v_pos, pix_x, pix_y, pix_rgb}, 0);
    check("rst_mid_flags", {pixel_valid, frame_start, locked, timing_err, err_count, probe_rgb, probe_valid}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_errcnt", err_count, 0);
    finish_frame();
    run_frames(2);
    check("rst_relock_early", locked, 0);
    run_frames(1);
    check("rst_relock", locked, 1);

    // 300 bad line lengths: counter saturates, every bad edge still pulses once.
    te0 = te_cnt;
    repeat (300) run_line(5);
    run_line(HT);
    check("sat_errcnt", err_count, 8'hFF);
    check("sat_te", te_cnt - te0, 300);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
